// File: rtl/pb_irq_controller.sv
// -----------------------------------------------------------------------------
// pb_irq_controller
// Vectored interrupt controller sitting in front of the PicoBlaze core's single
// interrupt / interrupt_ack pair. Up to NUM_SRC rising-edge sources are latched
// as pending, qualified by a mask and a global enable, and the lowest-numbered
// qualified source is presented to the core. Software reads the vector and
// clears the source through the core's I/O port bus.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   irq_src        interrupt sources (synchronous to clk, rising-edge triggered)
//   port_id        core I/O address
//   out_port       core write data
//   write_strobe   OUTPUT strobe, full 8-bit address decode
//   k_write_strobe OUTPUTK strobe, low-nibble address decode
//   read_strobe    INPUT strobe, only advances the debug read counter
//   in_port        registered read data (register addressed last cycle)
//   interrupt      interrupt request to the core
//   interrupt_ack  acknowledge from the core
//   rd_count       wrapping count of read_strobe pulses hitting a mapped register
//
// Register map (offset from BASE_ADDR):
//   +0 PENDING  read, write-1-to-clear
//   +1 MASK     read/write, 1 = source enabled
//   +2 VECTOR   read only, bit7 = in-service valid, bits[2:0] = active index
//   +3 CTRL     read/write, bit0 = global enable
// -----------------------------------------------------------------------------
module pb_irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               k_write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         in_port,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [7:0]         rd_count
);

    // Bits at or above NUM_SRC are forced to zero everywhere.
    localparam logic [7:0] SRC_MASK     = 8'hFF >> (8 - NUM_SRC);
    localparam logic [7:0] ADDR_PENDING = BASE_ADDR;
    localparam logic [7:0] ADDR_MASK    = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_VECTOR  = BASE_ADDR + 8'd2;
    localparam logic [7:0] ADDR_CTRL    = BASE_ADDR + 8'd3;

    // IDLE -> PREP latches the winning index; PREP -> ASSERT raises interrupt.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREP    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [7:0] irq_ext_s;
    logic [7:0] prev_r;
    logic [7:0] pending_r;
    logic [7:0] mask_r;
    logic       ctrl_en_r;
    logic [7:0] set_s;
    logic [7:0] clr_s;
    logic [7:0] req_s;
    logic       wr_pending_s;
    logic       wr_mask_s;
    logic       wr_ctrl_s;
    logic [7:0] vector_s;
    logic [7:0] read_data_s;
    logic       read_hit_s;
    state_t     state_r;
    logic       interrupt_r;
    logic [2:0] active_idx_r;
    logic       vec_valid_r;
    logic [7:0] in_port_r;
    logic [7:0] rd_count_r;

    // Widen the source vector to the fixed 8-bit internal datapath.
    always_comb begin
        irq_ext_s              = 8'h00;
        irq_ext_s[NUM_SRC-1:0] = irq_src;
    end

    // Write decode: OUTPUT uses the full address, OUTPUTK only the low nibble.
    always_comb begin
        wr_pending_s = (write_strobe   && (port_id == ADDR_PENDING)) ||
                       (k_write_strobe && (port_id[3:0] == ADDR_PENDING[3:0]));
        wr_mask_s    = (write_strobe   && (port_id == ADDR_MASK)) ||
                       (k_write_strobe && (port_id[3:0] == ADDR_MASK[3:0]));
        wr_ctrl_s    = (write_strobe   && (port_id == ADDR_CTRL)) ||
                       (k_write_strobe && (port_id[3:0] == ADDR_CTRL[3:0]));
    end

    // Edge detect, W1C clear term and the qualified request vector.
    always_comb begin
        set_s = irq_ext_s & ~prev_r & SRC_MASK;
        if (wr_pending_s) begin
            clr_s = out_port & SRC_MASK;
        end else begin
            clr_s = 8'h00;
        end
        req_s    = pending_r & mask_r;
        vector_s = {vec_valid_r, 4'b0000, active_idx_r};
    end

    // Read mux over the full 8-bit address; unmapped addresses read zero.
    always_comb begin
        read_data_s = 8'h00;
        read_hit_s  = 1'b1;
        case (port_id)
            ADDR_PENDING: read_data_s = pending_r;
            ADDR_MASK:    read_data_s = mask_r;
            ADDR_VECTOR:  read_data_s = vector_s;
            ADDR_CTRL:    read_data_s = {7'b0000000, ctrl_en_r};
            default: begin
                read_data_s = 8'h00;
                read_hit_s  = 1'b0;
            end
        endcase
    end

    // Register block: edge history, pending (set beats clear), mask, enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r    <= 8'hFF;
            pending_r <= 8'h00;
            mask_r    <= 8'h00;
            ctrl_en_r <= 1'b0;
        end else begin
            prev_r    <= irq_ext_s;
            pending_r <= ((pending_r & ~clr_s) | set_s) & SRC_MASK;
            if (wr_mask_s) begin
                mask_r <= out_port & SRC_MASK;
            end
            if (wr_ctrl_s) begin
                ctrl_en_r <= out_port[0];
            end
        end
    end

    // Request FSM with registered interrupt and vector outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            interrupt_r  <= 1'b0;
            active_idx_r <= 3'd0;
            vec_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    interrupt_r <= 1'b0;
                    vec_valid_r <= 1'b0;
                    if (ctrl_en_r && (req_s != 8'h00)) begin
                        active_idx_r <= lowest_index(req_s);
                        state_r      <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    // Committed: mask/enable changes no longer retract the request.
                    interrupt_r <= 1'b1;
                    state_r     <= ST_ASSERT;
                end
                ST_ASSERT: begin
                    if (interrupt_ack) begin
                        interrupt_r <= 1'b0;
                        vec_valid_r <= 1'b1;
                        state_r     <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (!pending_r[active_idx_r]) begin
                        vec_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    interrupt_r <= 1'b0;
                    vec_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered read data and the wrapping debug read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_port_r  <= 8'h00;
            rd_count_r <= 8'h00;
        end else begin
            in_port_r <= read_data_s;
            if (read_strobe && read_hit_s) begin
                rd_count_r <= rd_count_r + 8'd1;
            end
        end
    end

    assign in_port   = in_port_r;
    assign interrupt = interrupt_r;
    assign rd_count  = rd_count_r;

endmodule

// File: tb/tb_pb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_pb_irq_controller
// Self-checking bench for pb_irq_controller: a register-access vector table,
// hand-written multi-cycle sequences, and a randomized phase compared against a
// behavioural reference model.
// -----------------------------------------------------------------------------
module tb_pb_irq_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_src;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] rd_count;

    int total = 0;
    int bad   = 0;

    pb_irq_controller #(.NUM_SRC(8), .BASE_ADDR(8'hF0)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .in_port        (in_port),
        .interrupt      (interrupt),
        .interrupt_ack  (interrupt_ack),
        .rd_count       (rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       use_k;
        logic [7:0] wport;
        logic [7:0] wdata;
        logic [7:0] rport;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    // reference model state
    logic [7:0] m_pend, m_mask, m_prev, m_idx, m_rc;
    logic       m_en, m_fired;
    int         m_fire_at;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        port_id = p;
        tick();
        v = in_port;
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while (interrupt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, {7'd0, interrupt}, 8'h01);
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    function automatic logic [7:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 8'(i);
        return 8'd0;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] p);
        if (p == 8'hF0) return m_pend;
        if (p == 8'hF1) return m_mask;
        if (p == 8'hF2) return m_idx;   // never acked in random phase: bit7 stays 0
        if (p == 8'hF3) return {7'd0, m_en};
        return 8'h00;
    endfunction

    initial begin
        logic [7:0] v;
        logic [7:0] ports [9];
        logic [7:0] exp_in, clr;
        int         off;

        ports = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF7, 8'h00, 8'h01, 8'h32, 8'hA3};

        tbl[0]  = '{1'b0, 8'hF1, 8'hFF, 8'hF1, 8'hFF};
        tbl[1]  = '{1'b0, 8'hF1, 8'h05, 8'hF1, 8'h05};
        tbl[2]  = '{1'b1, 8'h01, 8'h3C, 8'hF1, 8'h3C};
        tbl[3]  = '{1'b1, 8'h21, 8'h5A, 8'hF1, 8'h5A};
        tbl[4]  = '{1'b0, 8'h01, 8'h00, 8'hF1, 8'h5A};
        tbl[5]  = '{1'b0, 8'hF3, 8'hFF, 8'hF3, 8'h01};
        tbl[6]  = '{1'b1, 8'h93, 8'h00, 8'hF3, 8'h00};
        tbl[7]  = '{1'b0, 8'hF2, 8'hFF, 8'hF2, 8'h00};
        tbl[8]  = '{1'b0, 8'hF0, 8'hFF, 8'hF0, 8'h00};
        tbl[9]  = '{1'b0, 8'hF7, 8'hFF, 8'hF7, 8'h00};
        tbl[10] = '{1'b0, 8'hF1, 8'h05, 8'hF4, 8'h00};
        tbl[11] = '{1'b0, 8'hF3, 8'h01, 8'hF3, 8'h01};

        rst = 1'b1; irq_src = 8'h00; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
        interrupt_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("reset_interrupt", {7'd0, interrupt}, 8'h00);
        check("reset_rd_count", rd_count, 8'h00);
        for (int a = 0; a < 4; a++) begin
            rd(8'hF0 + 8'(a), v);
            check("reset_reg", v, 8'h00);
        end

        // register access table
        for (int i = 0; i < 12; i++) begin
            port_id = tbl[i].wport; out_port = tbl[i].wdata;
            write_strobe = ~tbl[i].use_k; k_write_strobe = tbl[i].use_k;
            tick();
            write_strobe = 1'b0; k_write_strobe = 1'b0;
            port_id = tbl[i].rport; read_strobe = 1'b1;
            tick();
            read_strobe = 1'b0;
            check($sformatf("table_%0d", i), in_port, tbl[i].exp);
        end
        check("table_rd_count", rd_count, 8'd10);

        // 1: single source, latency, ack, vector, clear
        port_id = 8'hF0;
        irq_src = 8'h04; tick(); irq_src = 8'h00;
        check("t1_irq_lat1", {7'd0, interrupt}, 8'h00);
        tick();
        check("t1_irq_lat2", {7'd0, interrupt}, 8'h00);
        check("t1_pending", in_port, 8'h04);
        tick();
        check("t1_irq_up", {7'd0, interrupt}, 8'h01);
        ack();
        check("t1_irq_down", {7'd0, interrupt}, 8'h00);
        rd(8'hF2, v);
        check("t1_vector_svc", v, 8'h82);
        wr(8'hF0, 8'h04);
        tick();
        rd(8'hF2, v);
        check("t1_vector_idle", v, 8'h02);

        // 2: simultaneous sources, priority order
        irq_src = 8'h05; tick(); irq_src = 8'h00;
        wait_irq("t2_irq_a");
        ack();
        rd(8'hF2, v);
        check("t2_vector_a", v, 8'h80);
        wr(8'hF0, 8'h01);
        check("t2_gap", {7'd0, interrupt}, 8'h00);
        wait_irq("t2_irq_b");
        ack();
        rd(8'hF2, v);
        check("t2_vector_b", v, 8'h82);
        wr(8'hF0, 8'h04);
        tick(); tick();

        // 3: masked source, then unmask
        irq_src = 8'h08; tick(); irq_src = 8'h00;
        repeat (4) tick();
        check("t3_masked_quiet", {7'd0, interrupt}, 8'h00);
        rd(8'hF0, v);
        check("t3_pending", v, 8'h08);
        wr(8'hF1, 8'h0D);
        wait_irq("t3_unmasked_irq");
        ack();
        rd(8'hF2, v);
        check("t3_vector", v, 8'h83);
        wr(8'hF0, 8'h08);
        tick(); tick();

        // 4: disable while asserting
        irq_src = 8'h01; tick(); irq_src = 8'h00;
        wait_irq("t4_irq");
        wr(8'hF3, 8'h00);
        repeat (3) tick();
        check("t4_held", {7'd0, interrupt}, 8'h01);
        ack();
        check("t4_dropped", {7'd0, interrupt}, 8'h00);
        rd(8'hF2, v);
        check("t4_vector", v, 8'h80);
        wr(8'hF0, 8'h01);
        tick(); tick();
        irq_src = 8'h04; tick(); irq_src = 8'h00;
        repeat (6) tick();
        check("t4_disabled_quiet", {7'd0, interrupt}, 8'h00);
        rd(8'hF0, v);
        check("t4_pending", v, 8'h04);

        // 5: source high across reset, then set/clear collision
        irq_src = 8'h02;
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        rd(8'hF0, v);
        check("t5_no_edge", v, 8'h00);
        irq_src = 8'h00; tick();
        irq_src = 8'h02; tick();
        rd(8'hF0, v);
        check("t5_edge", v, 8'h02);
        irq_src = 8'h00; tick();
        irq_src = 8'h02;
        wr(8'hF0, 8'h02);
        irq_src = 8'h00;
        rd(8'hF0, v);
        check("t5_set_wins", v, 8'h02);

        // 6: asynchronous reset while asserting
        wr(8'hF1, 8'h02);
        wr(8'hF3, 8'h01);
        wait_irq("t6_irq");
        rst = 1'b1;
        #1;
        check("t6_async_irq", {7'd0, interrupt}, 8'h00);
        tick();
        rst = 1'b0;
        rd(8'hF0, v); check("t6_pending", v, 8'h00);
        rd(8'hF1, v); check("t6_mask", v, 8'h00);
        rd(8'hF3, v); check("t6_ctrl", v, 8'h00);
        read_strobe = 1'b1;
        rd(8'hF7, v);
        read_strobe = 1'b0;
        check("t6_unmapped", v, 8'h00);
        check("t6_rd_count", rd_count, 8'h00);
        check("t6_irq_low", {7'd0, interrupt}, 8'h00);

        // randomized phase against the reference model (no acknowledges)
        rst = 1'b1; irq_src = 8'h00; tick(); rst = 1'b0;
        m_pend = 8'h00; m_mask = 8'h00; m_en = 1'b0; m_prev = 8'hFF;
        m_idx = 8'h00; m_rc = 8'h00; m_fired = 1'b0; m_fire_at = 0;
        for (int c = 0; c < 400; c++) begin
            irq_src        = 8'($urandom) & 8'($urandom);
            port_id        = ports[$urandom_range(0, 8)];
            out_port       = 8'($urandom);
            write_strobe   = ($urandom_range(0, 3) == 0);
            k_write_strobe = ($urandom_range(0, 5) == 0);
            read_strobe    = 1'($urandom_range(0, 1));

            exp_in = model_read(port_id);
            if (read_strobe && port_id >= 8'hF0 && port_id <= 8'hF3) m_rc = m_rc + 8'd1;
            if (!m_fired && m_en && ((m_pend & m_mask) != 8'h00)) begin
                m_fired = 1'b1; m_fire_at = c; m_idx = lowest(m_pend & m_mask);
            end
            clr = 8'h00;
            for (int r = 0; r < 4; r++) begin
                off = r;
                if ((write_strobe && int'(port_id) - 240 == off) ||
                    (k_write_strobe && int'(port_id[3:0]) == off)) begin
                    if (r == 0) clr = out_port;
                    if (r == 1) m_mask = out_port;
                    if (r == 3) m_en = out_port[0];
                end
            end
            m_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
            m_prev = irq_src;

            tick();
            check("rand_in_port", in_port, exp_in);
            check("rand_interrupt", {7'd0, interrupt},
                  {7'd0, (m_fired && c >= m_fire_at + 1)});
            check("rand_rd_count", rd_count, m_rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pb_irq_controller.md
Name: pb_irq_controller

Overview:
- Vectored interrupt controller in front of the PicoBlaze core's single `interrupt`/`interrupt_ack` pair.
- Collects up to NUM_SRC rising-edge interrupt sources and latches them as pending.
- Applies a mask and a global enable, and picks the lowest-numbered pending source as highest priority.
- Holds `interrupt` to the core until acknowledged; software reads the vector and clears the source over the core's I/O port bus.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8).
- BASE_ADDR, 8'hF0, I/O port base for the register block. Must be 4-aligned.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- irq_src  input  NUM_SRC  interrupt sources, synchronous to clk, rising-edge triggered
- port_id  input  8  core I/O address
- out_port  input  8  core write data
- write_strobe  input  1  OUTPUT strobe; decode on the full 8-bit port_id
- k_write_strobe  input  1  OUTPUTK strobe; decode on port_id[3:0] against BASE_ADDR[3:0]+offset
- read_strobe  input  1  INPUT strobe; used only for the debug read counter, no side effects
- in_port  output  8  read data
- interrupt  output  1  interrupt request to core
- interrupt_ack  input  1  acknowledge from core
- rd_count  output  8  wrapping count of read_strobe pulses that hit a mapped register

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 PENDING: read; write-1-to-clear.
  - +1 MASK: read/write; 1 = enabled.
  - +2 VECTOR: read only; bit7 = in-service valid, bits[2:0] = active index, other bits 0.
  - +3 CTRL: read/write; bit0 = global enable, other bits read 0.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Unmapped port_id reads 8'h00.
- in_port is registered: it reflects the register addressed by the previous cycle's port_id, updated every cycle and not gated by read_strobe.
- Edge detect: previous-sample register resets to all ones, so a source high across reset release does not raise pending. pending[i] is set when irq_src[i]=1 and prev[i]=0.
- Set/clear collision: if a set and a W1C of the same bit land in the same cycle, the set wins.
- Reset values: pending, MASK, CTRL, VECTOR, interrupt, in_port and rd_count are all 0; FSM goes to IDLE.
- FSM:
  - IDLE: when CTRL[0]=1 and (pending & MASK) != 0, latch active index = lowest set bit of (pending & MASK). Next cycle go to ASSERT with interrupt=1.
  - ASSERT: interrupt=1, held until interrupt_ack=1. Then go to SERVICE and drop interrupt the following cycle.
    - Masking the source or clearing CTRL[0] in ASSERT does not retract the request.
    - If the active pending bit is cleared in ASSERT, still wait for ack.
  - SERVICE: VECTOR[7]=1. Return to IDLE in the cycle after pending[active]=0 is observed. No new request issues from SERVICE.
  - interrupt_ack outside ASSERT is ignored.
- Minimum spacing: two consecutive interrupt assertions are separated by at least one IDLE cycle with interrupt=0.
- VECTOR[7] is 1 only in SERVICE. The index field holds its last value otherwise.
- rd_count wraps from 8'hFF to 8'h00.
- Reset mid-operation clears all state asynchronously; interrupt falls without waiting for ack.

Test Plan:
1. Reset, then write MASK=0x05 and CTRL=0x01, pulse irq_src[2] -> PENDING reads 0x04; interrupt rises 2 cycles after the pending bit sets. Ack -> interrupt low next cycle; VECTOR reads 0x82. Write 0x04 to PENDING -> FSM returns to IDLE; VECTOR reads 0x02.
2. irq_src[0] and irq_src[2] pulse in the same cycle with MASK=0x05 -> VECTOR 0x80 first. After clearing bit 0, a second interrupt arrives with VECTOR 0x82.
3. Pulse source 3 with MASK=0x05 -> pending[3]=1, interrupt stays 0. Write MASK=0x0D -> interrupt asserts.
4. In ASSERT, write CTRL=0x00 -> interrupt held until ack, then no further request while CTRL[0]=0.
5. Hold irq_src[1] high through reset release -> PENDING=0x00. Then low and high again -> PENDING=0x02. Apply a W1C of 0x02 in the same cycle as a new edge -> PENDING stays 0x02.
6. Assert rst while in ASSERT -> interrupt=0 immediately; PENDING, MASK and CTRL read 0x00. Read port 0xF7 -> in_port 0x00 and rd_count unchanged.
